// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding reused by the bench to probe state.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle of the bit-serial subtractor.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             bor_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             bout;
  logic             ovf;

  modport master (
    output start, ain, bin, bor_in,
    input  busy, done, dout, bout, ovf
  );

  modport slave (
    input  start, ain, bin, bor_in,
    output busy, done, dout, bout, ovf
  );

endinterface

// File: rtl/serial_sub_full_sub.sv
// One-bit combinational full subtractor: o_dout = i_ain - i_bin - i_bin_b, with borrow out.
module full_sub (
  input  logic i_ain,
  input  logic i_bin,
  input  logic i_bin_b,
  output logic o_dout,
  output logic o_bout
);

  assign o_dout = i_ain ^ i_bin ^ i_bin_b;
  assign o_bout = (~i_ain & i_bin) | (~(i_ain ^ i_bin) & i_bin_b);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock through a single
// full_sub cell; result valid from the done pulse until the next accepted request.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);

  localparam int unsigned    CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_brw;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;

  full_sub u_cell (
    .i_ain   (r_a_sh[0]),
    .i_bin   (r_b_sh[0]),
    .i_bin_b (r_brw),
    .o_dout  (w_d),
    .o_bout  (w_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_last = (r_cnt == CNT_LAST);
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath; status flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_dout <= '0;
      r_cnt  <= '0;
      r_brw  <= 1'b0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_BUSY);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a_sh <= bus.ain;
        r_b_sh <= bus.bin;
        r_brw  <= bus.bor_in;
        r_cnt  <= '0;
        r_dout <= '0;
      end else if (r_state == S_BUSY) begin
        r_dout <= {w_d, r_dout[WIDTH-1:1]};
        r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_brw  <= w_bo;
        // Counter holds on the final bit so it never wraps inside an operation.
        if (w_last) begin
          r_bout <= w_bo;
          r_ovf  <= r_brw ^ w_bo;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dout = r_dout;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: WIDTH=8 directed/random checks and an exhaustive WIDTH=4 sweep.
module tb_serial_sub;
  import serial_sub_pkg::*;

  typedef struct {
    int d;
    int bo;
    int ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst8;
  logic rst4;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) if8 ();
  serial_sub_if #(.WIDTH(4)) if4 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
  serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t q8[$];
  exp_t q4[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Arithmetic reference: plain integer subtraction, unsigned borrow and signed range test.
  function automatic exp_t model(input int w, input int a, input int b, input int c);
    exp_t e;
    int full, half, sa, sb, sr;
    full = 1 << w;
    half = 1 << (w - 1);
    e.d  = (a - b - c + full) % full;
    e.bo = (a < b + c) ? 1 : 0;
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    sr   = sa - sb - c;
    e.ov = (sr < -half || sr > half - 1) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst8) begin
      chk("excl8", int'(if8.busy & if8.done), 0);
      if (if8.done) begin
        if (q8.size() == 0) chk("sb8_underflow", q8.size(), 1);
        else begin
          e = q8.pop_front();
          chk("dout8", int'(if8.dout), e.d);
          chk("bout8", int'(if8.bout), e.bo);
          chk("ovf8", int'(if8.ovf), e.ov);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst4 && if4.done) begin
      if (q4.size() == 0) chk("sb4_underflow", q4.size(), 1);
      else begin
        e = q4.pop_front();
        chk("dout4", int'(if4.dout), e.d);
        chk("bout4", int'(if4.bout), e.bo);
        chk("ovf4", int'(if4.ovf), e.ov);
      end
    end
  end

  task automatic idle8();
    @(negedge clk);
    for (int k = 0; k < 40 && (if8.busy || if8.done); k++) @(negedge clk);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    idle8();
    if8.ain = a; if8.bin = b; if8.bor_in = c; if8.start = 1'b1;
    q8.push_back(model(8, int'(a), int'(b), int'(c)));
    @(posedge clk); #1;
    if8.start = 1'b0; if8.ain = ~a; if8.bin = ~b; if8.bor_in = ~c;
    lat = 40;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if8.done) begin lat = k; break; end
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    for (int k = 0; k < 40 && (if4.busy || if4.done); k++) @(negedge clk);
    if4.ain = a; if4.bin = b; if4.bor_in = c; if4.start = 1'b1;
    q4.push_back(model(4, int'(a), int'(b), int'(c)));
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int k = 0; k < 40 && !if4.done; k++) begin @(posedge clk); #1; end
  endtask

  initial begin
    int lat, busy_n, done_n;
    if8.start = 1'b0; if8.ain = '0; if8.bin = '0; if8.bor_in = 1'b0;
    if4.start = 1'b0; if4.ain = '0; if4.bin = '0; if4.bor_in = 1'b0;
    rst8 = 1'b1; rst4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(if8.busy), 0);
    chk("rst_done", int'(if8.done), 0);
    chk("rst_dout", int'(if8.dout), 0);
    chk("rst_bout", int'(if8.bout), 0);
    chk("rst_ovf", int'(if8.ovf), 0);
    chk("rst_state", int'(dut8.r_state), int'(S_IDLE));
    rst8 = 1'b0; rst4 = 1'b0;

    op8(8'h05, 8'h03, 1'b0, lat);
    chk("latency", lat, 8);
    op8(8'h03, 8'h05, 1'b0, lat);
    op8(8'h80, 8'h01, 1'b0, lat);
    op8(8'h00, 8'h00, 1'b1, lat);

    // Start pulsed mid-operation must be ignored.
    idle8();
    if8.ain = 8'h3C; if8.bin = 8'h51; if8.bor_in = 1'b0; if8.start = 1'b1;
    q8.push_back(model(8, 'h3C, 'h51, 0));
    @(posedge clk); #1;
    if8.start = 1'b0;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 14; k++) begin
      busy_n += int'(if8.busy);
      done_n += int'(if8.done);
      if (k == 3) begin if8.start = 1'b1; if8.ain = 8'hC8; if8.bin = 8'h0F; if8.bor_in = 1'b1; end
      if (k == 4) if8.start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_cycles", busy_n, 8);
    chk("done_cycles", done_n, 1);

    op8(8'h7F, 8'hFF, 1'b0, lat);

    // Reset on the 4th busy cycle aborts the operation.
    idle8();
    if8.ain = 8'hA5; if8.bin = 8'h00; if8.bor_in = 1'b0; if8.start = 1'b1;
    q8.push_back(model(8, 'hA5, 0, 0));
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(if8.busy), 0);
    chk("abort_done", int'(if8.done), 0);
    chk("abort_dout", int'(if8.dout), 0);
    chk("abort_bout", int'(if8.bout), 0);
    chk("abort_ovf", int'(if8.ovf), 0);
    chk("abort_state", int'(dut8.r_state), int'(S_IDLE));
    q8.delete();
    rst8 = 1'b0;

    op8(8'h5A, 8'h33, 1'b1, lat);
    chk("latency_after_abort", lat, 8);

    for (int i = 0; i < 40; i++) op8(8'($urandom()), 8'($urandom()), 1'($urandom()), lat);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(4'(a), 4'(b), 1'(c));

    repeat (12) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
